// File: rtl/perception_pkg.sv
// ---------------------------------------------------------------------------
// perception_pkg
// Shared definitions for the perception-timer auto responder.
//   - seven-segment patterns (active-low, bit order gfedcba) for blank and
//     the digits 1..3 that the game can prompt
//   - button ID width/count and a one-hot helper
//   - FSM state encoding used by auto_responder
// ---------------------------------------------------------------------------
package perception_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ONE   = 7'b1111001;
    localparam logic [6:0] SEG_TWO   = 7'b0100100;
    localparam logic [6:0] SEG_THREE = 7'b0110000;

    localparam int BUTTON_ID_W  = 2;
    localparam int BUTTON_COUNT = 3;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_QUALIFY    = 3'd1,
        ST_DELAY      = 3'd2,
        ST_PRESS      = 3'd3,
        ST_WAIT_CLEAR = 3'd4
    } state_t;

    // Button IDs are 1-based (1..3) so they read the same as the digit;
    // ID 0 is unused and maps to no button.
    function automatic logic [BUTTON_COUNT-1:0] buttonOneHot(
        input logic [BUTTON_ID_W-1:0] id
    );
        logic [BUTTON_COUNT-1:0] result;
        result = '0;
        case (id)
            2'd1:    result = 3'b001;
            2'd2:    result = 3'b010;
            2'd3:    result = 3'b100;
            default: result = 3'b000;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/seg7_to_button.sv
// ---------------------------------------------------------------------------
// seg7_to_button
// Combinational decoder from an active-low seven-segment pattern to the
// button that answers it.
//   seg_i       [6:0]  segment pattern, active-low, gfedcba
//   buttonId_o  [1:0]  button ID 1..3 (0 when not a valid digit)
//   valid_o            high when seg_i is one of the digits 1, 2 or 3
// ---------------------------------------------------------------------------
module seg7_to_button
    import perception_pkg::*;
(
    input  logic [6:0]             seg_i,
    output logic [BUTTON_ID_W-1:0] buttonId_o,
    output logic                   valid_o
);

    // Only the three digits the game can ask for are recognised; everything
    // else, including blank, is reported as invalid.
    always_comb begin
        buttonId_o = '0;
        valid_o    = 1'b0;
        case (seg_i)
            SEG_ONE: begin
                buttonId_o = 2'd1;
                valid_o    = 1'b1;
            end
            SEG_TWO: begin
                buttonId_o = 2'd2;
                valid_o    = 1'b1;
            end
            SEG_THREE: begin
                buttonId_o = 2'd3;
                valid_o    = 1'b1;
            end
            default: begin
                buttonId_o = '0;
                valid_o    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/auto_responder.sv
// ---------------------------------------------------------------------------
// auto_responder
// Simulated player for the perception-timer game: watches the prompt digit,
// waits for it to be stable, waits a programmable reaction delay and then
// presses the matching button for HOLD_CYCLES cycles.
//   iClk             clock, all logic on the rising edge
//   iRst             synchronous active-high reset (highest priority)
//   iEnable          low forces the responder idle
//   iHexPrompt [6:0] prompt segments, active-low, gfedcba
//   iDelay    [15:0] reaction delay in cycles, sampled on prompt acceptance
//   oButtonsPressed [2:0] one-hot button press (bit0 = button 1)
//   oBusy            high whenever the FSM is not idle
//   oError           one-cycle pulse when an accepted prompt is not 1..3
//   oPressCount [7:0] number of presses issued, wrapping
// ---------------------------------------------------------------------------
module auto_responder
    import perception_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 16
) (
    input  logic                    iClk,
    input  logic                    iRst,
    input  logic                    iEnable,
    input  logic [6:0]              iHexPrompt,
    input  logic [15:0]             iDelay,
    output logic [BUTTON_COUNT-1:0] oButtonsPressed,
    output logic                    oBusy,
    output logic                    oError,
    output logic [7:0]              oPressCount
);

    localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    state_t                  state_q,   state_d;
    logic [6:0]              latch_q,   latch_d;
    logic [STAB_W-1:0]       stab_q,    stab_d;
    logic [HOLD_W-1:0]       hold_q,    hold_d;
    logic [15:0]             delay_q,   delay_d;
    logic [BUTTON_ID_W-1:0]  btnId_q,   btnId_d;
    logic [BUTTON_COUNT-1:0] buttons_q, buttons_d;
    logic                    error_q,   error_d;
    logic                    busy_q,    busy_d;
    logic [7:0]              count_q,   count_d;

    logic [6:0]             decodeSeg;
    logic [BUTTON_ID_W-1:0] decodeId;
    logic                   decodeValid;
    logic                   promptChanged;

    // In IDLE the candidate is the live prompt (it is being latched this
    // cycle); everywhere else the latched prompt is what gets accepted.
    assign decodeSeg     = (state_q == ST_IDLE) ? iHexPrompt : latch_q;
    assign promptChanged = (iHexPrompt != latch_q);

    seg7_to_button uDecoder (
        .seg_i      (decodeSeg),
        .buttonId_o (decodeId),
        .valid_o    (decodeValid)
    );

    // Next-state and next-output logic. Outputs are computed here as _d
    // values and registered below, so every output is a flop.
    always_comb begin
        logic              acceptNow;
        logic [STAB_W-1:0] stabNext;

        state_d   = state_q;
        latch_d   = latch_q;
        stab_d    = stab_q;
        hold_d    = hold_q;
        delay_d   = delay_q;
        btnId_d   = btnId_q;
        buttons_d = '0;
        error_d   = 1'b0;
        count_d   = count_q;
        acceptNow = 1'b0;
        stabNext  = stab_q + 1'b1;

        if (!iEnable) begin
            state_d = ST_IDLE;
            latch_d = SEG_BLANK;
            stab_d  = '0;
            hold_d  = '0;
            delay_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (iHexPrompt != SEG_BLANK) begin
                        latch_d   = iHexPrompt;
                        stab_d    = STAB_W'(1);
                        state_d   = ST_QUALIFY;
                        acceptNow = (STABLE_CYCLES <= 1);
                    end
                end
                ST_QUALIFY: begin
                    if (promptChanged) begin
                        state_d = ST_IDLE;
                        latch_d = SEG_BLANK;
                        stab_d  = '0;
                    end else begin
                        stab_d    = stabNext;
                        acceptNow = (stabNext == STAB_W'(STABLE_CYCLES));
                    end
                end
                ST_DELAY: begin
                    if (promptChanged) begin
                        state_d = ST_IDLE;
                        latch_d = SEG_BLANK;
                        delay_d = '0;
                    end else if (delay_q == 16'd0) begin
                        // The press count steps once, on the entry edge.
                        state_d   = ST_PRESS;
                        buttons_d = buttonOneHot(btnId_q);
                        hold_d    = HOLD_W'(1);
                        count_d   = count_q + 8'd1;
                    end else begin
                        delay_d = delay_q - 16'd1;
                    end
                end
                ST_PRESS: begin
                    // hold_q counts the press cycles already shown, so the
                    // button stays up for exactly HOLD_CYCLES cycles.
                    if (hold_q >= HOLD_W'(HOLD_CYCLES)) begin
                        state_d = ST_WAIT_CLEAR;
                        hold_d  = '0;
                    end else begin
                        hold_d    = hold_q + 1'b1;
                        buttons_d = buttonOneHot(btnId_q);
                    end
                end
                ST_WAIT_CLEAR: begin
                    if (promptChanged) begin
                        state_d = ST_IDLE;
                        latch_d = SEG_BLANK;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    latch_d = SEG_BLANK;
                    stab_d  = '0;
                    hold_d  = '0;
                    delay_d = '0;
                end
            endcase

            if (acceptNow) begin
                stab_d = '0;
                if (decodeValid) begin
                    state_d = ST_DELAY;
                    delay_d = iDelay;
                    btnId_d = decodeId;
                end else begin
                    state_d = ST_WAIT_CLEAR;
                    error_d = 1'b1;
                end
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; synchronous reset overrides everything.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q   <= ST_IDLE;
            latch_q   <= SEG_BLANK;
            stab_q    <= '0;
            hold_q    <= '0;
            delay_q   <= '0;
            btnId_q   <= '0;
            buttons_q <= '0;
            error_q   <= 1'b0;
            busy_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            latch_q   <= latch_d;
            stab_q    <= stab_d;
            hold_q    <= hold_d;
            delay_q   <= delay_d;
            btnId_q   <= btnId_d;
            buttons_q <= buttons_d;
            error_q   <= error_d;
            busy_q    <= busy_d;
            count_q   <= count_d;
        end
    end

    assign oButtonsPressed = buttons_q;
    assign oBusy           = busy_q;
    assign oError          = error_q;
    assign oPressCount     = count_q;

endmodule

// File: doc/auto_responder.md
AUTO_RESPONDER -- requirements
Module: auto_responder

Purpose: a simulated player for the perception-timer game. It reads the prompt digit shown on a seven-segment display. After a programmable reaction delay it presses the matching button, so the timer can be exercised without a human.

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive identical prompt cycles required before the prompt is accepted.
REQ-002 Parameter HOLD_CYCLES, default 16: number of cycles a button stays asserted per press.
REQ-003 iClk  input  1  single clock; all logic rising-edge.
REQ-004 iRst  input  1  reset, synchronous, active-high.
REQ-005 iEnable  input  1  high = responder active; low = forced idle, no presses.
REQ-006 iHexPrompt  input  7  prompt display segments, active-low, bit order gfedcba.
REQ-007 iDelay  input  16  reaction delay in cycles, sampled when a prompt is accepted.
REQ-008 oButtonsPressed  output  3  active-high, one-hot while pressing; bit0=button 1, bit1=button 2, bit2=button 3.
REQ-009 oBusy  output  1  high in any state other than IDLE.
REQ-010 oError  output  1  one-cycle pulse when the accepted prompt is not a valid digit.
REQ-011 oPressCount  output  8  count of presses issued; wraps from 255 to 0.

Function
REQ-012 Blank pattern 7'b1111111; valid prompts: "1"=7'b1111001 -> button 1, "2"=7'b0100100 -> button 2, "3"=7'b0110000 -> button 3.
REQ-013 FSM states: IDLE, QUALIFY, DELAY, PRESS, WAIT_CLEAR.
REQ-014 IDLE: on a non-blank iHexPrompt, latch it, set the stability counter to 1, and go to QUALIFY.
REQ-015 QUALIFY, prompt differs from latch: go to IDLE.
REQ-016 QUALIFY, prompt equal to latch: increment the counter.
REQ-017 When the counter reaches STABLE_CYCLES, decode the latch:
  - valid digit -> DELAY, with the delay counter loaded from iDelay;
  - invalid digit -> pulse oError for one cycle, then WAIT_CLEAR.
REQ-018 DELAY, delay counter 0: enter PRESS next cycle (iDelay=0 gives press on the cycle after acceptance).
REQ-019 DELAY, delay counter nonzero: decrement it.
REQ-020 In DELAY, a prompt change aborts to IDLE with no press and no count increment.
REQ-021 PRESS: oButtonsPressed is the decoded one-hot for exactly HOLD_CYCLES cycles; oPressCount increments once, on entry.
REQ-022 PRESS ignores prompt changes until the hold completes; the FSM then goes to WAIT_CLEAR.
REQ-023 WAIT_CLEAR: go to IDLE on the first cycle iHexPrompt differs from latch (blank or new digit); the same prompt is never pressed twice.
REQ-024 iEnable low in any state: next cycle IDLE, oButtonsPressed=0, counters cleared, oPressCount held.
REQ-025 oButtonsPressed is nonzero only in PRESS, and never has more than one bit set.
REQ-026 All outputs are registered.

Reset
REQ-027 Reset values:
  - state IDLE;
  - oButtonsPressed=3'b000, oBusy=0, oError=0, oPressCount=0;
  - latch=blank, all counters 0.
REQ-028 Reset mid-PRESS releases the button on the cycle after iRst is sampled high and does not increment oPressCount.
REQ-029 Reset has priority over iEnable and all other inputs.

Structure
REQ-030 Shared package perception_pkg holds:
  - segment constants for BLANK and digits 1-3;
  - FSM state encoding;
  - button ID width (2) and button count (3).
REQ-031 Sub-module seg7_to_button: combinational decoder, 7-bit pattern -> 2-bit button ID plus valid flag; instantiated once.
REQ-032 Counter widths:
  - stability counter: $clog2(STABLE_CYCLES+1);
  - hold counter: $clog2(HOLD_CYCLES+1);
  - delay counter: 16 bits.

Verification
REQ-033 Prompt "2" held steady, iDelay=10 -> oButtonsPressed=3'b010 asserted 4+10+1 cycles after first seen (STABLE_CYCLES=4, delay 10, +1 for the DELAY-to-PRESS transition), held 16 cycles; oPressCount 0->1.
REQ-034 Prompt "1" shown for only 3 cycles, then blank -> no press, oBusy returns to 0, oPressCount unchanged.
REQ-035 Prompt "3" accepted, then changed to "1" during delay 100 -> no press for "3"; "1" is then qualified and pressed (3'b001).
REQ-036 Prompt 7'b0000000 ("8") held -> oError single pulse after 4 cycles, no press, returns to IDLE only when prompt changes.
REQ-037 iRst high during PRESS -> next cycle all outputs at reset values; iEnable=0 during DELAY -> no press, count held.
REQ-038 256 valid press sequences -> oPressCount wraps to 0; prompt held constant after a press -> exactly one press.
